ex_result_stage: RTL and testbench
==================================

EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  EX stage presents an instruction this cycle.
REQ-005 alu_out  input  16  result from ALU/shifter datapath (shifter dst, adder sum, logic result).
REQ-006 alu_ov  input  1  signed-overflow indication from adder; ignored unless op_cls=00.
REQ-007 op_cls  input  2  flag class: 00 arith (Z,V,N), 01 logic/shift (Z only), 10 no-flag, 11 reserved (treated as 10).
REQ-008 rd  input  4  destination register index.
REQ-009 reg_we  input  1  instruction writes rd.
REQ-010 stall  input  1  downstream hold; freeze all state.
REQ-011 flush  input  1  squash instruction in EX; insert bubble.
REQ-012 out_valid  output  1  registered valid to MEM stage.
REQ-013 out_result  output  16  registered result.
REQ-014 out_rd  output  4  registered destination index.
REQ-015 out_we  output  1  registered register-write enable.
REQ-016 flag_z, flag_v, flag_n  output  1 each  architectural flag register.
REQ-017 instr_cnt  output  16  count of instructions accepted.

Function
REQ-018 Accept condition: acc = in_valid & ~stall & ~flush, evaluated each rising edge.
REQ-019 On acc, next cycle: out_valid=1, out_result=alu_out, out_rd=rd, out_we=reg_we & (rd!=0).
REQ-020 rd=0 SHALL never produce out_we=1 (R0 hardwired zero); out_result still captured.
REQ-021 Latency SHALL be exactly one cycle from accepted input to registered output.
REQ-022 flush=1 (regardless of stall): next cycle out_valid=0, out_we=0; out_result/out_rd SHALL hold previous values; flags and instr_cnt unchanged.
REQ-023 stall=1 and flush=0: all outputs, flags and instr_cnt SHALL hold; in_valid ignored.
REQ-024 flush takes priority over stall when both asserted.
REQ-025 in_valid=0, stall=0, flush=0: bubble, same as REQ-022.
REQ-026 Flag update only on acc: op_cls=00 -> Z=(alu_out==16'h0000), V=alu_ov, N=alu_out[15]; op_cls=01 -> Z updated, V and N hold; op_cls=10/11 -> all hold.
REQ-027 Flags SHALL be visible the cycle after the accepting edge, aligned with out_valid.
REQ-028 instr_cnt SHALL increment by 1 on each acc, wrapping 16'hFFFF -> 16'h0000 without saturation.
REQ-029 Flags and instr_cnt SHALL be independent of reg_we (a no-write arith op still updates flags).
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 On rst at rising edge: out_valid=0, out_result=16'h0000, out_rd=4'h0, out_we=0, flag_z=0, flag_v=0, flag_n=0, instr_cnt=16'h0000.
REQ-032 rst SHALL override stall, flush and in_valid in the same cycle; an instruction presented with rst is discarded.
REQ-033 First accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-034 Arith: op_cls=00, alu_out=16'h8000, alu_ov=1, rd=3, reg_we=1 -> next cycle out_valid=1, out_result=8000, out_we=1, Z=0,V=1,N=1, instr_cnt=1.
REQ-035 Shift Z-only: prior flags Z=0,V=1,N=1; op_cls=01, alu_out=16'h0000 (SRL of 0x0001 by 1) -> Z=1, V=1, N=1 held.
REQ-036 Stall/flush: accept A (result 0x1234); then stall=1 two cycles with in_valid=1 result 0xFFFF -> outputs stay 0x1234, counter unchanged; then stall=1,flush=1 -> out_valid=0, out_we=0, flags unchanged.
REQ-037 R0 write: rd=0, reg_we=1, op_cls=00, alu_out=16'h0000 -> out_we=0, out_valid=1, Z=1.
REQ-038 Counter wrap: force 65535 accepts (or 65536 from reset) -> instr_cnt 16'hFFFF then 16'h0000 on next accept.
REQ-039 Reset mid-stream: rst=1 with in_valid=1, stall=0 -> all outputs per REQ-031 next cycle; no flag or counter update.

Source files
------------

// File: rtl/ex_result_stage.sv
// EX/MEM result register: captures the ALU result, maintains the Z/V/N flag
// register and counts accepted instructions, with stall/flush pipeline control.
module ex_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] alu_out,
  input  logic        alu_ov,
  input  logic [1:0]  op_cls,
  input  logic [3:0]  rd,
  input  logic        reg_we,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic [15:0] instr_cnt
);

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_NONE  = 2'b10,
    CLS_RSVD  = 2'b11
  } op_cls_e;

  logic    acc;
  logic    bubble;
  logic    res_zero;
  op_cls_e cls;

  assign acc      = in_valid & ~stall & ~flush;
  // Flush wins over stall; an idle, unstalled cycle also drains the stage.
  assign bubble   = flush | (~stall & ~in_valid);
  assign res_zero = (alu_out == 16'h0000);
  assign cls      = op_cls_e'(op_cls);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_rd     <= 4'h0;
      out_we     <= 1'b0;
    end else if (acc) begin
      out_valid  <= 1'b1;
      out_result <= alu_out;
      out_rd     <= rd;
      out_we     <= reg_we & (rd != 4'h0);
    end else if (bubble) begin
      // Result and destination keep their last values; only the qualifiers drop.
      out_valid  <= 1'b0;
      out_we     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (acc) begin
      case (cls)
        CLS_ARITH: begin
          flag_z <= res_zero;
          flag_v <= alu_ov;
          flag_n <= alu_out[15];
        end
        CLS_LOGIC: flag_z <= res_zero;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= 16'h0000;
    end else if (acc) begin
      instr_cnt <= instr_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] alu_out;
  logic        alu_ov;
  logic [1:0]  op_cls;
  logic [3:0]  rd;
  logic        reg_we;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [15:0] instr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, expressed as the architectural view of the stage.
  bit          m_valid;
  bit [15:0]   m_result;
  bit [3:0]    m_rd;
  bit          m_we;
  bit          m_z, m_v, m_n;
  int unsigned m_accepts;

  ex_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .alu_out    (alu_out),
    .alu_ov     (alu_ov),
    .op_cls     (op_cls),
    .rd         (rd),
    .reg_we     (reg_we),
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply the rules of the stage to the inputs just sampled by the clock edge.
  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_result = '0; m_rd = '0; m_we = 0;
      m_z = 0; m_v = 0; m_n = 0; m_accepts = 0;
    end else if (flush || (!stall && !in_valid)) begin
      m_valid = 0;
      m_we    = 0;
    end else if (!stall) begin
      m_valid  = 1;
      m_result = alu_out;
      m_rd     = rd;
      m_we     = reg_we && (rd != 0);
      m_accepts++;
      if (op_cls == 2'b00) begin
        m_z = (alu_out == 0);
        m_v = alu_ov;
        m_n = alu_out[15];
      end else if (op_cls == 2'b01) begin
        m_z = (alu_out == 0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  {15'd0, out_valid}, {15'd0, m_valid});
    check({tag, ".result"}, out_result,         m_result);
    check({tag, ".rd"},     {12'd0, out_rd},    {12'd0, m_rd});
    check({tag, ".we"},     {15'd0, out_we},    {15'd0, m_we});
    check({tag, ".z"},      {15'd0, flag_z},    {15'd0, m_z});
    check({tag, ".v"},      {15'd0, flag_v},    {15'd0, m_v});
    check({tag, ".n"},      {15'd0, flag_n},    {15'd0, m_n});
    check({tag, ".cnt"},    instr_cnt,          m_accepts[15:0]);
  endtask

  // Advance one clock; inputs change #1 after the edge, outputs are sampled there too.
  task automatic step(input string tag, input bit do_check);
    @(posedge clk);
    #1;
    model_edge();
    if (do_check) check_all(tag);
  endtask

  task automatic drive(input bit v, input bit [15:0] res, input bit ov, input bit [1:0] cls,
                       input bit [3:0] d, input bit we, input bit st, input bit fl);
    in_valid = v; alu_out = res; alu_ov = ov; op_cls = cls;
    rd = d; reg_we = we; stall = st; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 16'hBEEF, 1, 2'b00, 4'h5, 1, 0, 0);
    step("reset", 1);
    check("reset.cnt_zero", instr_cnt, 16'h0000);
    rst = 1'b0;

    // Arithmetic accept on the first edge after reset.
    drive(1, 16'h8000, 1, 2'b00, 4'h3, 1, 0, 0);
    step("arith", 1);
    check("arith.result", out_result, 16'h8000);
    check("arith.vn", {14'd0, flag_v, flag_n}, 16'h0003);
    check("arith.cnt", instr_cnt, 16'h0001);

    // Shift result zero: only Z moves.
    drive(1, 16'h0000, 0, 2'b01, 4'h4, 1, 0, 0);
    step("shift", 1);
    check("shift.zvn", {13'd0, flag_z, flag_v, flag_n}, 16'h0007);

    // Stall holds everything, then flush+stall drops valid only.
    drive(1, 16'h1234, 0, 2'b10, 4'h6, 1, 0, 0);
    step("accA", 1);
    drive(1, 16'hFFFF, 0, 2'b00, 4'h7, 1, 1, 0);
    step("stall1", 1);
    step("stall2", 1);
    check("stall.result", out_result, 16'h1234);
    check("stall.cnt", instr_cnt, 16'h0003);
    drive(1, 16'hFFFF, 0, 2'b00, 4'h7, 1, 1, 1);
    step("flush", 1);
    check("flush.vw", {14'd0, out_valid, out_we}, 16'h0000);
    check("flush.result", out_result, 16'h1234);

    // R0 write suppressed, flags still updated.
    drive(1, 16'h0000, 0, 2'b00, 4'h0, 1, 0, 0);
    step("r0", 1);
    check("r0.vwz", {13'd0, out_valid, out_we, flag_z}, 16'h0005);

    // No-write arithmetic op still updates flags.
    drive(1, 16'hF000, 1, 2'b00, 4'h9, 0, 0, 0);
    step("nowe", 1);

    // Reset mid-stream discards the presented instruction.
    rst = 1'b1;
    drive(1, 16'h5555, 1, 2'b00, 4'h2, 1, 0, 0);
    step("rst_mid", 1);
    check("rst_mid.result", out_result, 16'h0000);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 80,
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom), 2'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom), $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
      step("rand", 1);
    end

    // Counter wrap: 65535 accepts from reset, then one more.
    rst = 1'b1;
    step("wrap_rst", 1);
    rst = 1'b0;
    drive(1, 16'h0001, 0, 2'b10, 4'h1, 1, 0, 0);
    for (int i = 0; i < 65535; i++) step("wrap", 0);
    check_all("wrap_ffff");
    check("wrap.ffff", instr_cnt, 16'hFFFF);
    step("wrap_0", 1);
    check("wrap.zero", instr_cnt, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
